// File: rtl/multdiv_pkg.sv
// Shared definitions for x_multdiv_unit: FSM states, iteration count, operation encoding.
// The DIV state only exists when MULTDIV_DIV_EN is defined.
package multdiv_pkg;

    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
`ifdef MULTDIV_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Magnitude of a two's-complement value; 0x80000000 maps to itself as unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_iter_datapath.sv
// Radix-2 iterative datapath: 64-bit accumulator, shift-add / restoring-subtract step, sign fix-up.
// Divider step and fix-up are compiled only when MULTDIV_DIV_EN is defined.
module multdiv_iter_datapath
    import multdiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
`ifdef MULTDIV_DIV_EN
    input  op_e         op_i,
`endif
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    output logic [31:0] result_o,
    output logic        exception_o
);

    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] mag_q;
    logic        neg_q;
    logic [32:0] sum;
    logic [63:0] prod;
`ifdef MULTDIV_DIV_EN
    op_e         op_q;
    logic        zero_q;
    logic [32:0] trial;
    logic [31:0] quot;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
`ifdef MULTDIV_DIV_EN
            op_q   <= OP_MUL;
            zero_q <= 1'b0;
`endif
        end else if (load_i) begin
            neg_q <= opa_i[31] ^ opb_i[31];
`ifdef MULTDIV_DIV_EN
            op_q   <= op_i;
            zero_q <= (opb_i == '0);
            if (op_i == OP_DIV) begin
                acc_q <= {32'd0, abs32(opa_i)};
                mag_q <= abs32(opb_i);
            end else begin
                acc_q <= {32'd0, abs32(opb_i)};
                mag_q <= abs32(opa_i);
            end
`else
            acc_q <= {32'd0, abs32(opb_i)};
            mag_q <= abs32(opa_i);
`endif
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    // Result is fixed up from the stepped value so the last iteration's outcome is ready at its own edge.
    always_comb begin
        sum         = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
        acc_d       = {sum, acc_q[31:1]};
        prod        = neg_q ? (~acc_d + 64'd1) : acc_d;
        result_o    = prod[31:0];
        exception_o = !((&prod[63:31]) || !(|prod[63:31]));
`ifdef MULTDIV_DIV_EN
        trial = {1'b0, acc_q[62:31]} - {1'b0, mag_q};
        quot  = '0;
        if (op_q == OP_DIV) begin
            acc_d = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
            quot  = acc_d[31:0];
            if (zero_q) begin
                result_o    = '0;
                exception_o = 1'b1;
            end else begin
                result_o    = neg_q ? (~quot + 32'd1) : quot;
                exception_o = !neg_q && quot[31];
            end
        end
`endif
    end

endmodule

// File: rtl/x_multdiv_unit.sv
// Multicycle signed multiply/divide unit with stall handshake: FSM, iteration counter, result registers.
// Divide support is enabled by defining MULTDIV_DIV_EN.
module x_multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic        stall,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;
    logic        start_div;
    logic        start;
    logic        busy;
    logic        last_iter;
    logic [31:0] dp_result;
    logic        dp_exception;

`ifdef MULTDIV_DIV_EN
    assign start_div = ctrl_DIV;
    assign busy      = (state_q == ST_MULT) || (state_q == ST_DIV);
`else
    logic unused_ctrl_div;
    assign unused_ctrl_div = ctrl_DIV;
    assign start_div       = 1'b0;
    assign busy            = (state_q == ST_MULT);
`endif

    assign start     = (state_q == ST_IDLE) && (ctrl_MULT || start_div);
    assign last_iter = (cnt_q == 5'(ITER_COUNT - 1));
    assign stall     = busy || start;

    multdiv_iter_datapath u_datapath (
        .clk_i       (clock),
        .rst_ni      (reset),
        .load_i      (start),
        .step_i      (busy),
`ifdef MULTDIV_DIV_EN
        .op_i        (ctrl_MULT ? OP_MUL : OP_DIV),
`endif
        .opa_i       (data_operandA),
        .opb_i       (data_operandB),
        .result_o    (dp_result),
        .exception_o (dp_exception)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b0;
                    if (ctrl_MULT) begin
                        state_q <= ST_MULT;
                        cnt_q   <= '0;
                    end
`ifdef MULTDIV_DIV_EN
                    else if (start_div) begin
                        state_q <= ST_DIV;
                        cnt_q   <= '0;
                    end
`endif
                end
                ST_MULT
`ifdef MULTDIV_DIV_EN
                , ST_DIV
`endif
                : begin
                    cnt_q <= cnt_q + 5'd1;
                    if (last_iter) begin
                        state_q  <= ST_DONE;
                        rdy_q    <= 1'b1;
                        result_q <= dp_result;
                        exc_q    <= dp_exception;
                    end
                end
                ST_DONE: begin
                    rdy_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_x_multdiv_unit.sv
// Directed self-checking bench for x_multdiv_unit; divide cases run only when MULTDIV_DIV_EN is defined.
module tb_x_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic        stall;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int total = 0;
    int bad = 0;
    int stall_hi;
    int rdy_cnt;

    x_multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall          (stall),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Start edge is edge 0; a result seen in the cycle before edge N is reported as edge N.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d, input int div_at,
                          input logic [31:0] exp_res, input logic exp_exc);
        int          s_hi = 0;
        int          r_cnt = 0;
        int          r_edge = -1;
        logic [31:0] res = '0;
        logic        exc = 1'b0;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        #1;
        if (stall === 1'b1) s_hi++;
        @(posedge clock);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV  = (i + 1 == div_at);
            #1;
            if (stall === 1'b1) s_hi++;
            if (data_resultRDY === 1'b1) begin
                r_cnt++;
                if (r_edge < 0) begin
                    r_edge = i + 1;
                    res    = data_result;
                    exc    = data_exception;
                end
            end
        end
        ctrl_DIV = 1'b0;
        chk({tag, "_stall_cycles"}, 32'(s_hi), 32'd33);
        chk({tag, "_rdy_count"}, 32'(r_cnt), 32'd1);
        chk({tag, "_rdy_edge"}, 32'(r_edge), 32'd33);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_exception"}, {31'd0, exc}, {31'd0, exp_exc});
        chk({tag, "_result_held"}, data_result, exp_res);
    endtask

    initial begin
        #12;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_7_m3", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 0, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 0, 32'h0000_0000, 1'b1);
        run_op("mul_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'h8000_0000, 1'b1);
        run_op("mul_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 32'h0000_0001, 1'b0);
        run_op("mul_busy_div", 32'hFFFF_FFFB, 32'd6, 1'b1, 1'b0, 10, 32'hFFFF_FFE2, 1'b0);

        // Reset in the middle of a multiply
        @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exception", {31'd0, data_exception}, 32'd0);
        chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        stall_hi = 0;
        rdy_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            #1;
            if (stall === 1'b1) stall_hi++;
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        chk("midrst_no_rdy", 32'(rdy_cnt), 32'd0);
        chk("midrst_no_stall", 32'(stall_hi), 32'd0);
        run_op("mul_3_4", 32'd3, 32'd4, 1'b1, 1'b0, 0, 32'd12, 1'b0);

`ifdef MULTDIV_DIV_EN
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 0, 32'hFFFF_FFFD, 1'b0);
        run_op("div_5_0", 32'd5, 32'd0, 1'b0, 1'b1, 0, 32'd0, 1'b1);
        run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 32'h8000_0000, 1'b1);
        run_op("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1, 0, 32'hFFFF_FFF2, 1'b0);
        run_op("both_is_mul", 32'd6, 32'd3, 1'b1, 1'b1, 0, 32'd18, 1'b0);
`else
        @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd1;
        ctrl_DIV      = 1'b1;
        stall_hi = 0;
        rdy_cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall === 1'b1) stall_hi++;
            if (data_resultRDY === 1'b1) rdy_cnt++;
            @(negedge clock);
        end
        ctrl_DIV = 1'b0;
        chk("nodiv_stall", 32'(stall_hi), 32'd0);
        chk("nodiv_rdy", 32'(rdy_cnt), 32'd0);
        chk("nodiv_result_kept", data_result, 32'd12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
